// File: rtl/fifo_pkg.sv
// Shared types and helpers for the dual-clock FIFO read-side stream logic.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } rd_state_t;

  // Burst index width; a one-beat burst still needs a 1-bit index.
  function automatic int unsigned burst_w(input int unsigned burst);
    return (burst <= 1) ? 1 : $clog2(burst);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus the outgoing valid/ready stream of fifo_rd_stream.
interface fifo_rd_stream_if #(
  parameter int unsigned DSIZE  = 8,
  parameter int unsigned CWIDTH = 16
) ();

  logic [DSIZE-1:0]  rdata;
  logic              rempty;
  logic              rinc;
  logic              flush;
  logic [DSIZE-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [CWIDTH-1:0] beat_cnt;

  modport master (
    input  rdata, rempty, flush, m_ready,
    output rinc, m_data, m_valid, m_last, beat_cnt
  );

  modport slave (
    output rdata, rempty, flush, m_ready,
    input  rinc, m_data, m_valid, m_last, beat_cnt
  );

endinterface

// File: rtl/fifo_skid2.sv
// Two-entry in-order buffer; entry 0 is the head. Clear drops all entries.
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [DSIZE-1:0] i_data,
  output logic [DSIZE-1:0] o_data,
  output rd_state_t        o_state
);

  rd_state_t        r_state;
  rd_state_t        w_state_nxt;
  logic [DSIZE-1:0] r_e0;
  logic [DSIZE-1:0] r_e1;
  logic [DSIZE-1:0] w_e0_nxt;
  logic [DSIZE-1:0] w_e1_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_e0    <= '0;
      r_e1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_e0    <= w_e0_nxt;
      r_e1    <= w_e1_nxt;
    end
  end

  // Clear wins over everything; a pop in the same cycle is simply absorbed.
  always_comb begin
    w_state_nxt = r_state;
    w_e0_nxt    = r_e0;
    w_e1_nxt    = r_e1;
    if (i_clear) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (i_push) begin
            w_state_nxt = ST_ONE;
            w_e0_nxt    = i_data;
          end
        end
        ST_ONE: begin
          if (i_push && !i_pop) begin
            w_state_nxt = ST_FULL;
            w_e1_nxt    = i_data;
          end else if (!i_push && i_pop) begin
            w_state_nxt = ST_EMPTY;
          end else if (i_push && i_pop) begin
            w_e0_nxt    = i_data;
          end
        end
        ST_FULL: begin
          if (i_pop) begin
            w_state_nxt = ST_ONE;
            w_e0_nxt    = r_e1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign o_data  = r_e0;
  assign o_state = r_state;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain FIFO consumer: pops into a 2-entry buffer and re-presents the
// words as a registered valid/ready stream with burst framing and a beat count.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE  = 8,
  parameter int unsigned BURST  = 4,
  parameter int unsigned CWIDTH = 16
) (
  input  logic           rclk,
  input  logic           rrst,
  fifo_rd_stream_if.master bus
);

  localparam int unsigned BW = burst_w(BURST);

  rd_state_t         w_state;
  logic [DSIZE-1:0]  w_head;
  logic              w_rinc;
  logic              w_valid;
  logic              w_hs;
  logic              w_idx_wrap;
  logic [BW-1:0]     r_idx;
  logic [CWIDTH-1:0] r_beat_cnt;

  // Fill decision uses only registered state and the FIFO flag, never m_ready.
  assign w_rinc     = !rrst && !bus.flush && !bus.rempty && (w_state != ST_FULL);
  assign w_valid    = (w_state != ST_EMPTY);
  assign w_hs       = w_valid && bus.m_ready;
  assign w_idx_wrap = (r_idx == BW'(BURST - 1));

  fifo_skid2 #(
    .DSIZE (DSIZE)
  ) u_skid (
    .i_clk   (rclk),
    .i_rst   (rrst),
    .i_push  (w_rinc),
    .i_pop   (w_hs),
    .i_clear (bus.flush),
    .i_data  (bus.rdata),
    .o_data  (w_head),
    .o_state (w_state)
  );

  // Burst index restarts on flush even if a beat completes in that cycle.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_idx <= '0;
    end else if (bus.flush) begin
      r_idx <= '0;
    end else if (w_hs) begin
      r_idx <= w_idx_wrap ? '0 : r_idx + BW'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_beat_cnt <= '0;
    end else if (w_hs) begin
      r_beat_cnt <= r_beat_cnt + CWIDTH'(1);
    end
  end

  assign bus.rinc     = w_rinc;
  assign bus.m_data   = w_head;
  assign bus.m_valid  = w_valid;
  assign bus.m_last   = w_valid && w_idx_wrap;
  assign bus.beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a BURST=4 instance for streaming, stall,
// flush and drain, plus a BURST=1/CWIDTH=4 instance for framing and wrap.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  logic rrst;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DSIZE(8), .CWIDTH(16)) ifa ();
  fifo_rd_stream_if #(.DSIZE(8), .CWIDTH(4))  ifb ();

  fifo_rd_stream #(.DSIZE(8), .BURST(4), .CWIDTH(16)) u_dut_a (
    .rclk (clk),
    .rrst (rrst),
    .bus  (ifa)
  );

  fifo_rd_stream #(.DSIZE(8), .BURST(1), .CWIDTH(4)) u_dut_b (
    .rclk (clk),
    .rrst (rrst),
    .bus  (ifb)
  );

  // Behavioural FIFO read side for each instance.
  logic [7:0] mem_a [0:63];
  logic [7:0] mem_b [0:63];
  int wp_a = 0;
  int rp_a = 0;
  int wp_b = 0;
  int rp_b = 0;

  assign ifa.rempty = (wp_a == rp_a);
  assign ifa.rdata  = mem_a[rp_a[5:0]];
  assign ifb.rempty = (wp_b == rp_b);
  assign ifb.rdata  = mem_b[rp_b[5:0]];

  // Handshake log and pop counters.
  logic [7:0] log_d [0:63];
  logic       log_l [0:63];
  int         log_t [0:63];
  int n_a       = 0;
  int rinc_a    = 0;
  int cyc       = 0;
  int n_b       = 0;
  int last_b    = 0;
  logic [7:0] data_b = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifa.rinc) begin
      rp_a   <= rp_a + 1;
      rinc_a <= rinc_a + 1;
    end
    if (ifa.m_valid && ifa.m_ready) begin
      log_d[n_a[5:0]] <= ifa.m_data;
      log_l[n_a[5:0]] <= ifa.m_last;
      log_t[n_a[5:0]] <= cyc;
      n_a             <= n_a + 1;
    end
    if (ifb.rinc) rp_b <= rp_b + 1;
    if (ifb.m_valid && ifb.m_ready) begin
      n_b    <= n_b + 1;
      data_b <= ifb.m_data;
      if (ifb.m_last) last_b <= last_b + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int r0;

  initial begin
    rrst        = 1'b1;
    ifa.flush   = 1'b0;
    ifa.m_ready = 1'b1;
    ifb.flush   = 1'b0;
    ifb.m_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    for (int i = 0; i < 8; i++) mem_a[i] = 8'(i + 1);
    wp_a = 8;

    // Reset held with a non-empty FIFO
    wait_cyc(3);
    chk("rst_rinc", 32'(ifa.rinc), 32'd0);
    chk("rst_valid", 32'(ifa.m_valid), 32'd0);
    chk("rst_data", 32'(ifa.m_data), 32'd0);
    chk("rst_cnt", 32'(ifa.beat_cnt), 32'd0);
    rrst = 1'b0;
    #1;
    chk("rel_rinc", 32'(ifa.rinc), 32'd1);
    chk("rel_valid", 32'(ifa.m_valid), 32'd0);
    wait_cyc(1);
    chk("first_valid", 32'(ifa.m_valid), 32'd1);
    chk("first_data", 32'(ifa.m_data), 32'h01);

    // Streaming 0x01..0x08
    wait_cyc(10);
    chk("stream_n", 32'(n_a), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stream_d%0d", i), 32'(log_d[i]), 32'(i + 1));
      chk($sformatf("stream_l%0d", i), 32'(log_l[i]), (i == 3 || i == 7) ? 32'd1 : 32'd0);
    end
    chk("stream_gap", 32'(log_t[7] - log_t[0]), 32'd7);
    chk("stream_cnt", 32'(ifa.beat_cnt), 32'd8);
    chk("stream_idle", 32'(ifa.m_valid), 32'd0);

    // Backpressure: buffer takes two words, then stops popping
    ifa.m_ready = 1'b0;
    mem_a[8]  = 8'h20;
    mem_a[9]  = 8'h21;
    mem_a[10] = 8'h22;
    wp_a = 11;
    r0 = rinc_a;
    wait_cyc(5);
    chk("bp_rinc_pulses", 32'(rinc_a - r0), 32'd2);
    chk("bp_rinc_now", 32'(ifa.rinc), 32'd0);
    chk("bp_hold_data", 32'(ifa.m_data), 32'h20);
    chk("bp_hold_valid", 32'(ifa.m_valid), 32'd1);
    chk("bp_hold_last", 32'(ifa.m_last), 32'd0);
    ifa.m_ready = 1'b1;
    wait_cyc(6);
    chk("bp_d0", 32'(log_d[8]), 32'h20);
    chk("bp_d1", 32'(log_d[9]), 32'h21);
    chk("bp_d2", 32'(log_d[10]), 32'h22);
    chk("bp_gap", 32'(log_t[10] - log_t[8]), 32'd2);
    chk("bp_cnt", 32'(ifa.beat_cnt), 32'd11);

    // Flush with 0x10/0x11 buffered; FIFO still holds 0x12..0x14
    ifa.m_ready = 1'b0;
    mem_a[11] = 8'h10;
    mem_a[12] = 8'h11;
    mem_a[13] = 8'h12;
    mem_a[14] = 8'h13;
    mem_a[15] = 8'h14;
    wp_a = 16;
    wait_cyc(4);
    chk("pre_flush_data", 32'(ifa.m_data), 32'h10);
    chk("pre_flush_last", 32'(ifa.m_last), 32'd1);
    ifa.m_ready = 1'b1;
    ifa.flush   = 1'b1;
    #1;
    chk("flush_rinc", 32'(ifa.rinc), 32'd0);
    wait_cyc(1);
    ifa.flush = 1'b0;
    chk("post_flush_valid", 32'(ifa.m_valid), 32'd0);
    chk("post_flush_cnt", 32'(ifa.beat_cnt), 32'd12);
    r0 = rinc_a;
    wait_cyc(8);
    chk("flush_d_kept", 32'(log_d[11]), 32'h10);
    chk("flush_l_kept", 32'(log_l[11]), 32'd1);
    chk("flush_next_d", 32'(log_d[12]), 32'h12);
    chk("flush_next_l", 32'(log_l[12]), 32'd0);
    chk("drain_d13", 32'(log_d[13]), 32'h13);
    chk("drain_d14", 32'(log_d[14]), 32'h14);
    chk("drain_l14", 32'(log_l[14]), 32'd0);
    chk("drain_rinc_pulses", 32'(rinc_a - r0), 32'd3);
    chk("drain_valid", 32'(ifa.m_valid), 32'd0);
    chk("drain_rinc", 32'(ifa.rinc), 32'd0);
    chk("drain_cnt", 32'(ifa.beat_cnt), 32'd15);

    // Refill continues framing at index 3
    mem_a[16] = 8'hAA;
    wp_a = 17;
    wait_cyc(3);
    chk("refill_n", 32'(n_a), 32'd16);
    chk("refill_d", 32'(log_d[15]), 32'hAA);
    chk("refill_l", 32'(log_l[15]), 32'd1);
    chk("refill_cnt", 32'(ifa.beat_cnt), 32'd16);

    // BURST=1, CWIDTH=4: 17 beats, every beat is last, counter wraps to 1
    for (int i = 0; i < 17; i++) mem_b[i] = 8'(8'h40 + i);
    wp_b = 17;
    wait_cyc(22);
    chk("b_beats", 32'(n_b), 32'd17);
    chk("b_lasts", 32'(last_b), 32'd17);
    chk("b_last_data", 32'(data_b), 32'h50);
    chk("b_cnt_wrap", 32'(ifb.beat_cnt), 32'd1);
    chk("b_idle", 32'(ifb.m_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
